// File: rtl/conv_pkg.sv
// Shared types and defaults for the line-buffered KxK convolution stage.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } conv_state_t;

    localparam int ADDR_W_DEF   = 11;
    localparam int ROW_W_DEF    = 11;
    localparam int KSIZE_DEF    = 3;
    // One line-buffer read plus one window shift; filter pipeline depth.
    localparam int WIN_LAT_DEF  = 2;
    localparam int FILT_LAT_DEF = 4;

endpackage

// File: rtl/conv_delay_pipe.sv
// Fixed-depth shift register; clears synchronously on resetn low.
module conv_delay_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sh [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) r_sh[i] <= '0;
        end else begin
            r_sh[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sh[i] <= r_sh[i-1];
        end
    end

    assign o_q = r_sh[DEPTH-1];

endmodule

// File: rtl/conv_line_ctrl.sv
// Frame sequencer for a line-buffered KxK convolution stage.
// Define CONV_STRIDE2_EN to emit only windows on even offsets (stride 2).
//
// state | meaning
// IDLE  | waiting for start; cfg latched and checked on start
// RUN   | accepting pixels, driving line buffers, flagging complete windows
// FLUSH | draining window and filter pipelines
// DONE  | one-cycle done pulse
module conv_line_ctrl
    import conv_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ROW_W    = ROW_W_DEF,
    parameter int KSIZE    = KSIZE_DEF,
    parameter int WIN_LAT  = WIN_LAT_DEF,
    parameter int FILT_LAT = FILT_LAT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_width,
    input  logic [ROW_W-1:0]  cfg_height,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              lb_wen,
    output logic              lb_ren,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_col,
    output logic [ROW_W-1:0]  win_row,
    output logic              out_valid
);

    localparam int                CNT_W      = $clog2(WIN_LAT + FILT_LAT + 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(WIN_LAT + FILT_LAT - 1);
    localparam logic [ADDR_W:0]   MAX_W      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   MIN_W      = (ADDR_W+1)'(KSIZE);
    localparam logic [ROW_W-1:0]  MIN_H      = ROW_W'(KSIZE);
    localparam logic [ADDR_W-1:0] KM1_C      = ADDR_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0]  KM1_R      = ROW_W'(KSIZE - 1);

    conv_state_t       r_state, w_next;
    logic [ADDR_W-1:0] r_col, r_col_last;
    logic [ROW_W-1:0]  r_row, r_row_last;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cfg_err;

    logic              w_acc, w_cfg_bad, w_col_end, w_row_end, w_last, w_win;
    logic [ADDR_W-1:0] w_win_col;
    logic [ROW_W-1:0]  w_win_row;
    logic              w_wv_d, w_ov_d;
    logic [ADDR_W-1:0] w_wc_d;
    logic [ROW_W-1:0]  w_wr_d;

    assign w_acc     = resetn && in_valid && (r_state == S_RUN);
    assign w_cfg_bad = (cfg_width < MIN_W) || (cfg_width > MAX_W) || (cfg_height < MIN_H);
    assign w_col_end = (r_col == r_col_last);
    assign w_row_end = (r_row == r_row_last);
    assign w_last    = w_acc && w_col_end && w_row_end;

`ifdef CONV_STRIDE2_EN
    // Even offset from K-1 is the same as matching its LSB.
    assign w_win = w_acc && (r_row >= KM1_R) && (r_col >= KM1_C)
                   && (r_row[0] == KM1_R[0]) && (r_col[0] == KM1_C[0]);
`else
    assign w_win = w_acc && (r_row >= KM1_R) && (r_col >= KM1_C);
`endif

    assign w_win_col = w_win ? r_col : '0;
    assign w_win_row = w_win ? r_row : '0;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = w_cfg_bad ? S_DONE : S_RUN;
            S_RUN: begin
                in_ready = resetn;
                busy     = resetn;
                if (w_last) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                busy = resetn;
                if (r_cnt == '0) w_next = S_DONE;
            end
            S_DONE: begin
                done   = resetn;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_col      <= '0;
            r_row      <= '0;
            r_col_last <= '0;
            r_row_last <= '0;
            r_cnt      <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_col      <= '0;
                r_row      <= '0;
                r_col_last <= ADDR_W'(cfg_width - (ADDR_W+1)'(1));
                r_row_last <= cfg_height - ROW_W'(1);
                r_cfg_err  <= w_cfg_bad;
            end
            if (w_acc) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + ADDR_W'(1);
                end
            end
            if (w_last)                                 r_cnt <= FLUSH_LAST;
            else if (r_state == S_FLUSH && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    conv_delay_pipe #(
        .DEPTH (WIN_LAT),
        .WIDTH (1 + ADDR_W + ROW_W)
    ) u_win_pipe (
        .clk    (clk),
        .resetn (resetn),
        .i_d    ({w_win, w_win_col, w_win_row}),
        .o_q    ({w_wv_d, w_wc_d, w_wr_d})
    );

    conv_delay_pipe #(
        .DEPTH (FILT_LAT),
        .WIDTH (1)
    ) u_out_pipe (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (w_wv_d),
        .o_q    (w_ov_d)
    );

    // Addresses equal col: the read returns the previous row before the write lands.
    assign lb_wen    = w_acc;
    assign lb_ren    = w_acc;
    assign lb_waddr  = resetn ? r_col : '0;
    assign lb_raddr  = resetn ? r_col : '0;
    assign cfg_err   = resetn && r_cfg_err;
    assign win_valid = resetn && w_wv_d;
    assign win_col   = resetn ? w_wc_d : '0;
    assign win_row   = resetn ? w_wr_d : '0;
    assign out_valid = resetn && w_ov_d;

endmodule

// File: tb/tb_conv_line_ctrl.sv
// Directed bench for conv_line_ctrl (K=3, WIN_LAT=2, FILT_LAT=4).
module tb_conv_line_ctrl;

`ifdef CONV_STRIDE2_EN
    localparam int STRIDE = 2;
    localparam int N_5X4  = 2;
    localparam int N_8X8  = 9;
    localparam int N_7X7  = 9;
`else
    localparam int STRIDE = 1;
    localparam int N_5X4  = 6;
    localparam int N_8X8  = 36;
    localparam int N_7X7  = 25;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [11:0] cfg_width = '0;
    logic [10:0] cfg_height = '0;
    logic        busy, done, cfg_err, in_ready;
    logic        in_valid = 1'b0;
    logic        lb_wen, lb_ren, win_valid, out_valid;
    logic [10:0] lb_waddr, lb_raddr, win_col;
    logic [10:0] win_row;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    conv_line_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lb_wen     (lb_wen),
        .lb_ren     (lb_ren),
        .lb_waddr   (lb_waddr),
        .lb_raddr   (lb_raddr),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .out_valid  (out_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive after the rising edge, sample 2 time units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"},      busy, 0);
        chk({tag, " in_ready"},  in_ready, 0);
        chk({tag, " lb_wen"},    lb_wen, 0);
        chk({tag, " lb_ren"},    lb_ren, 0);
        chk({tag, " win_valid"}, win_valid, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " done"},      done, 0);
        chk({tag, " lb_waddr"},  lb_waddr, 0);
    endtask

    task automatic run_frame(input int w, input int h, input bit gap, input int rst_at,
                             input bit mid_start, input int exp_win);
        int exp_r[$];
        int exp_c[$];
        int col = 0, row = 0;
        int n_acc = 0, n_win = 0, n_out = 0, n_done = 0;
        int first_acc = -1, first_win = -1, last_acc = -1, done_cyc = -1;
        bit tog = 1'b1, mid_done = 1'b0, aborted = 1'b0;

        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++)
                if ((r - 2) % STRIDE == 0 && (c - 2) % STRIDE == 0) begin
                    exp_r.push_back(r);
                    exp_c.push_back(c);
                end

        next_cycle();
        start = 1'b1; cfg_width = 12'(w); cfg_height = 11'(h); in_valid = 1'b0;
        #2;
        for (int t = 0; t < 2000; t++) begin
            next_cycle();
            start    = 1'b0;
            in_valid = gap ? tog : 1'b1;
            tog      = !tog;
            if (mid_start && !mid_done && n_acc == 7) begin
                start = 1'b1; cfg_width = 12'd4; cfg_height = 11'd3; mid_done = 1'b1;
            end
            if (rst_at >= 0 && n_acc == rst_at) begin
                resetn = 1'b0;
                #2;
                chk_quiet("abort_rst1");
                if (done) n_done++;
                next_cycle();
                #2;
                chk_quiet("abort_rst2");
                if (done) n_done++;
                resetn   = 1'b1;
                in_valid = 1'b0;
                aborted  = 1'b1;
                break;
            end
            #2;
            if (in_valid && in_ready) begin
                chk("lb_wen",   lb_wen, 1);
                chk("lb_ren",   lb_ren, 1);
                chk("lb_waddr", lb_waddr, col);
                chk("lb_raddr", lb_raddr, col);
                if (first_acc < 0 && row >= 2 && col >= 2) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
                if (col == w - 1) begin col = 0; row++; end
                else col++;
            end else begin
                chk("lb_wen_idle", lb_wen, 0);
            end
            if (win_valid) begin
                if (first_win < 0) first_win = cyc;
                if (n_win < exp_r.size()) begin
                    chk("win_row", win_row, exp_r[n_win]);
                    chk("win_col", win_col, exp_c[n_win]);
                end
                n_win++;
            end
            if (out_valid) n_out++;
            if (done) begin
                done_cyc = cyc;
                n_done++;
                chk("busy_at_done", busy, 0);
                break;
            end
        end

        if (aborted) begin
            chk("abort_accepts", n_acc, rst_at);
            chk("abort_no_done", n_done, 0);
        end else begin
            chk("done_seen",     n_done, 1);
            chk("accepts",       n_acc, w * h);
            chk("win_count",     n_win, exp_win);
            chk("out_count",     n_out, exp_win);
            chk("first_win_lat", first_win - first_acc, 2);
            chk("done_lat",      done_cyc - last_acc, 7);
            chk("cfg_err_clear", cfg_err, 0);
        end
    endtask

    task automatic cfg_bad(input int w, input int h);
        next_cycle();
        start = 1'b1; cfg_width = 12'(w); cfg_height = 11'(h); in_valid = 1'b1;
        #2;
        chk("bad_ready_start", in_ready, 0);
        next_cycle();
        start = 1'b0;
        #2;
        chk("bad_done",    done, 1);
        chk("bad_cfg_err", cfg_err, 1);
        chk("bad_ready",   in_ready, 0);
        chk("bad_busy",    busy, 0);
        next_cycle();
        #2;
        chk("bad_done_end", done, 0);
        chk("bad_sticky",   cfg_err, 1);
        chk("bad_ready2",   in_ready, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        #2;
        chk_quiet("reset");
        chk("reset cfg_err", cfg_err, 0);
        chk("reset win_row", win_row, 0);
        next_cycle();
        resetn = 1'b1;
        in_valid = 1'b0;
        #2;

        run_frame(5, 4, 1'b0, -1, 1'b0, N_5X4);
        run_frame(5, 4, 1'b1, -1, 1'b0, N_5X4);
        cfg_bad(2, 4);
        cfg_bad(5, 2);
        cfg_bad(2049, 4);
        run_frame(5, 4, 1'b0, -1, 1'b1, N_5X4);
        run_frame(8, 8, 1'b0, 30, 1'b0, N_8X8);
        run_frame(8, 8, 1'b0, -1, 1'b0, N_8X8);
        run_frame(7, 7, 1'b0, -1, 1'b0, N_7X7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
